multicycle_control_fsm: RTL and testbench

Multi-cycle RV32I control sequencer that drives the shared datapath: PC, IR, register file, a single ALU, and one unified instruction/data memory port. It fetches through a ready-handshaked memory port and decodes the latched opcode. Each cycle it emits Moore control selects that route operands, including the sign-extended immediate from the immediate generator, through the one ALU. It sits beside the datapath in the processor top level and is the only source of write-enables for PC, IR, register file and memory.

---
 rtl/multicycle_control_fsm.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Control sequencer for a multi-cycle RV32I datapath with a shared ALU and a
// single instruction/data memory port. Each state emits the datapath selects
// and write-enables it needs. In the fetch and memory-write states, the
// write-enables and done pulse are additionally qualified by the memory
// ready handshake.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an unknown
// opcode parks the FSM in a sticky trap state. When it is undefined, an
// unknown opcode is retired as a two-cycle NOP.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       branch_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic       instr_done_o,
  output logic       trap_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_FUNC = 2'b10;
  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_MEM    = 2'b01;
  localparam logic [1:0] RS_ALU    = 2'b10;

  state_t     state;
  state_t     next_state;
  logic [6:0] opcode_q;

  // State register; the opcode is captured while leaving DECODE so later
  // states are immune to IR-side changes on opcode_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      opcode_q <= 7'd0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        opcode_q <= opcode_i;
      end
    end
  end

  // Next-state logic; request states hold until the memory reports ready.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXEC_R;
          OP_ITYPE:          next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           next_state = S_ILLEGAL;
`else
          default:           next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   next_state = (opcode_q == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready_i ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = mem_ready_i ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   next_state = S_ALUWB;
      S_EXEC_I:   next_state = S_ALUWB;
      S_LUI:      next_state = S_ALUWB;
      S_AUIPC:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JALR:     next_state = S_JAL;
      S_JAL:      next_state = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  next_state = S_ILLEGAL;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  // Output decode; everything is forced low during reset so an aborted
  // instruction cannot write PC, registers or memory in the reset cycle.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = A_PC;
    alu_src_b_o  = B_RS2;
    alu_op_o     = OP_ADD;
    result_src_o = RS_ALUOUT;
    instr_done_o = 1'b0;
    trap_o       = 1'b0;
    state_o      = 4'd0;
    if (!rst) begin
      state_o = state;
      case (state)
        S_FETCH: begin
          mem_req_o    = 1'b1;
          ir_write_o   = mem_ready_i;
          pc_write_o   = mem_ready_i;
          alu_src_a_o  = A_PC;
          alu_src_b_o  = B_FOUR;
          result_src_o = RS_ALU;
        end
        S_DECODE: begin
          alu_src_a_o = A_OLDPC;
          alu_src_b_o = B_IMM;
        end
        S_MEMADR: begin
          alu_src_a_o = A_RS1;
          alu_src_b_o = B_IMM;
        end
        S_MEMREAD: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
        end
        S_MEMWB: begin
          result_src_o = RS_MEM;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req_o    = 1'b1;
          mem_we_o     = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_EXEC_R: begin
          alu_src_a_o = A_RS1;
          alu_src_b_o = B_RS2;
          alu_op_o    = OP_FUNC;
        end
        S_EXEC_I: begin
          alu_src_a_o = A_RS1;
          alu_src_b_o = B_IMM;
          alu_op_o    = OP_FUNC;
        end
        S_LUI: begin
          alu_src_a_o = A_ZERO;
          alu_src_b_o = B_IMM;
        end
        S_AUIPC: begin
          alu_src_a_o = A_OLDPC;
          alu_src_b_o = B_IMM;
        end
        S_ALUWB: begin
          result_src_o = RS_ALUOUT;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o  = A_RS1;
          alu_src_b_o  = B_RS2;
          alu_op_o     = OP_SUB;
          branch_o     = 1'b1;
          result_src_o = RS_ALUOUT;
          instr_done_o = 1'b1;
        end
        S_JALR: begin
          alu_src_a_o = A_RS1;
          alu_src_b_o = B_IMM;
        end
        S_JAL: begin
          pc_write_o   = 1'b1;
          result_src_o = RS_ALUOUT;
          alu_src_a_o  = A_OLDPC;
          alu_src_b_o  = B_FOUR;
        end
`ifdef ILLEGAL_TRAP_EN
        S_ILLEGAL: begin
          trap_o = 1'b1;
        end
`endif
        default: begin
          state_o = state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
// Drives instruction sequences into multicycle_control_fsm. For each driven
// cycle it pushes the expected output vector, taken from the per-state
// control table, to a scoreboard queue. The bench pops and compares that
// vector on the following falling edge.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] opcode_i;
  logic       mem_ready_i;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       iord_o;
  logic       ir_write_o;
  logic       pc_write_o;
  logic       branch_o;
  logic       reg_write_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic [1:0] result_src_o;
  logic       instr_done_o;
  logic       trap_o;
  logic [3:0] state_o;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9, JALR = 4'd10, JAL = 4'd11,
                         LUI = 4'd12, AUIPC = 4'd13, ILLEGAL = 4'd14;

  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_R = 7'b0110011,
                         OPC_I = 7'b0010011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_BAD = 7'b1111111;

  int checks = 0;
  int errors = 0;

  logic [20:0] expQ[$];
  string       tagQ[$];
  logic [20:0] actual;

  multicycle_control_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .opcode_i     (opcode_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .iord_o       (iord_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .branch_o     (branch_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .result_src_o (result_src_o),
    .instr_done_o (instr_done_o),
    .trap_o       (trap_o),
    .state_o      (state_o)
  );

  assign actual = {state_o, mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, branch_o,
                   reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
                   instr_done_o, trap_o};

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds the expected output vector from the per-state control table.
  function automatic logic [20:0] ex(input logic [3:0] st, input logic rdy);
    logic req, we, iord, irw, pcw, br, rw, done, trap;
    logic [1:0] a, b, op, rs;
    {req, we, iord, irw, pcw, br, rw, done, trap} = '0;
    {a, b, op, rs} = '0;
    case (st)
      FETCH:    begin req = 1; irw = rdy; pcw = rdy; a = 2'b00; b = 2'b10; rs = 2'b10; end
      DECODE:   begin a = 2'b01; b = 2'b01; end
      MEMADR:   begin a = 2'b10; b = 2'b01; end
      MEMREAD:  begin req = 1; iord = 1; end
      MEMWB:    begin rs = 2'b01; rw = 1; done = 1; end
      MEMWRITE: begin req = 1; we = 1; iord = 1; done = rdy; end
      EXEC_R:   begin a = 2'b10; b = 2'b00; op = 2'b10; end
      EXEC_I:   begin a = 2'b10; b = 2'b01; op = 2'b10; end
      LUI:      begin a = 2'b11; b = 2'b01; end
      AUIPC:    begin a = 2'b01; b = 2'b01; end
      ALUWB:    begin rs = 2'b00; rw = 1; done = 1; end
      BRANCH:   begin a = 2'b10; b = 2'b00; op = 2'b01; br = 1; done = 1; end
      JALR:     begin a = 2'b10; b = 2'b01; end
      JAL:      begin pcw = 1; a = 2'b01; b = 2'b10; end
      ILLEGAL:  begin trap = 1; end
      default:  begin end
    endcase
    return {st, req, we, iord, irw, pcw, br, rw, a, b, op, rs, done, trap};
  endfunction

  // Compares one observed value against its expectation and counts it.
  task automatic checkOutput(input string tag, input logic [20:0] got, input logic [20:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", tag, got, want);
    end
  endtask

  // Drives one cycle of inputs and queues the expected outputs for that cycle.
  task automatic applyStimulus(input string tag, input logic r, input logic [6:0] op,
                               input logic rdy, input logic [20:0] want);
    rst         = r;
    opcode_i    = op;
    mem_ready_i = rdy;
    expQ.push_back(want);
    tagQ.push_back(tag);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [6:0] op, input logic rdy, input logic [3:0] st);
    applyStimulus(tag, 1'b0, op, rdy, ex(st, rdy));
  endtask

  // Scoreboard side: pop and compare on the falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(tagQ.pop_front(), actual, expQ.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    opcode_i = 7'd0;
    mem_ready_i = 1'b0;

    applyStimulus("reset0", 1'b1, OPC_R, 1'b1, '0);
    applyStimulus("reset1", 1'b1, OPC_R, 1'b1, '0);

    // R-type, zero wait states
    step("r_fetch",  OPC_R, 1'b1, FETCH);
    step("r_decode", OPC_R, 1'b1, DECODE);
    step("r_exec",   OPC_R, 1'b1, EXEC_R);
    step("r_aluwb",  OPC_R, 1'b1, ALUWB);

    // Fetch wait, then load with two MEMREAD wait cycles; opcode_i changes
    // after DECODE to show dispatch uses the latched opcode
    step("ld_fetch_wait", OPC_LOAD, 1'b0, FETCH);
    step("ld_fetch",      OPC_LOAD, 1'b1, FETCH);
    step("ld_decode",     OPC_LOAD, 1'b1, DECODE);
    step("ld_memadr",     OPC_STORE, 1'b1, MEMADR);
    step("ld_read_w0",    OPC_STORE, 1'b0, MEMREAD);
    step("ld_read_w1",    OPC_STORE, 1'b0, MEMREAD);
    step("ld_read",       OPC_STORE, 1'b1, MEMREAD);
    step("ld_memwb",      OPC_STORE, 1'b1, MEMWB);

    // JALR
    step("jalr_fetch",  OPC_JALR, 1'b1, FETCH);
    step("jalr_decode", OPC_JALR, 1'b1, DECODE);
    step("jalr_jalr",   OPC_JALR, 1'b1, JALR);
    step("jalr_jal",    OPC_JALR, 1'b1, JAL);
    step("jalr_aluwb",  OPC_JALR, 1'b1, ALUWB);

    // Branch; ready in BRANCH is ignored
    step("br_fetch",  OPC_BR, 1'b1, FETCH);
    step("br_decode", OPC_BR, 1'b1, DECODE);
    step("br_branch", OPC_BR, 1'b1, BRANCH);

    // Store with zero wait states; opcode_i swapped to a load after DECODE
    step("st_fetch",  OPC_STORE, 1'b1, FETCH);
    step("st_decode", OPC_STORE, 1'b1, DECODE);
    step("st_memadr", OPC_LOAD, 1'b1, MEMADR);
    step("st_write",  OPC_LOAD, 1'b1, MEMWRITE);

    // I-type, LUI, AUIPC, JAL
    step("i_fetch",  OPC_I, 1'b1, FETCH);
    step("i_decode", OPC_I, 1'b1, DECODE);
    step("i_exec",   OPC_I, 1'b1, EXEC_I);
    step("i_aluwb",  OPC_I, 1'b1, ALUWB);
    step("lui_fetch",  OPC_LUI, 1'b1, FETCH);
    step("lui_decode", OPC_LUI, 1'b1, DECODE);
    step("lui_lui",    OPC_LUI, 1'b1, LUI);
    step("lui_aluwb",  OPC_LUI, 1'b1, ALUWB);
    step("auipc_fetch",  OPC_AUIPC, 1'b1, FETCH);
    step("auipc_decode", OPC_AUIPC, 1'b1, DECODE);
    step("auipc_auipc",  OPC_AUIPC, 1'b1, AUIPC);
    step("auipc_aluwb",  OPC_AUIPC, 1'b1, ALUWB);
    step("jal_fetch",  OPC_JAL, 1'b1, FETCH);
    step("jal_decode", OPC_JAL, 1'b1, DECODE);
    step("jal_jal",    OPC_JAL, 1'b1, JAL);
    step("jal_aluwb",  OPC_JAL, 1'b1, ALUWB);

    // Illegal opcode
    step("ill_fetch",  OPC_BAD, 1'b1, FETCH);
    step("ill_decode", OPC_BAD, 1'b1, DECODE);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      step("ill_sticky", OPC_R, logic'(i % 2), ILLEGAL);
    end
    applyStimulus("ill_reset", 1'b1, OPC_R, 1'b1, '0);
`else
    step("ill_nop_fetch",  OPC_R, 1'b1, FETCH);
    step("ill_nop_decode", OPC_R, 1'b1, DECODE);
    step("ill_nop_exec",   OPC_R, 1'b1, EXEC_R);
    step("ill_nop_aluwb",  OPC_R, 1'b1, ALUWB);
`endif

    // Reset during a MEMWRITE wait aborts the store
    step("rst_fetch",   OPC_STORE, 1'b1, FETCH);
    step("rst_decode",  OPC_STORE, 1'b1, DECODE);
    step("rst_memadr",  OPC_STORE, 1'b1, MEMADR);
    step("rst_write_w", OPC_STORE, 1'b0, MEMWRITE);
    applyStimulus("rst_in_write", 1'b1, OPC_STORE, 1'b0, '0);
    step("rst_after_fetch_w", OPC_STORE, 1'b0, FETCH);
    step("rst_after_fetch",   OPC_R, 1'b1, FETCH);
    step("rst_after_decode",  OPC_R, 1'b1, DECODE);

    @(negedge clk);
    #1;
    checkOutput("sb_empty", 21'(expQ.size()), 21'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
